s298_bist_ctrl: RTL and testbench
=================================

# s298_bist_ctrl

Built-in self-test sequencer for the s298 sequential core. It clears the core's 14 flip-flops through input G0, then drives pseudo-random stimulus on G0/G1/G2 from an 8-bit LFSR for a programmed number of cycles. It compacts the six core outputs into a 16-bit MISR and compares the final signature against a golden value. It sits beside the s298 instance and owns its primary inputs while a test is running.

## Interface
Parameters:
- PAT_CNT, 255: number of stimulus patterns per test; legal range 1..65535.
- CLR_CYCLES, 2: cycles G0 is held high to clear the core; legal range 1..15.
- LFSR_SEED, 8'h01: LFSR load value; 8'h00 is replaced by 8'h01.
- GOLDEN_SIG, 16'h0000: expected final MISR value.

Ports:
- CK, input, 1: clock; all state updates on the rising edge.
- RN, input, 1: reset, asynchronous, active-low.
- START, input, 1: begin a test; sampled only in IDLE or DONE.
- ABORT, input, 1: return to IDLE; has priority over START.
- OBS, input, 6: core outputs {G133,G132,G118,G117,G67,G66}.
- DUT_G, output, 3: registered drive to core inputs {G2,G1,G0}.
- BUSY, output, 1: high in CLEAR, RUN and FLUSH.
- DONE, output, 1: high in DONE.
- PASS, output, 1: signature match; valid only while DONE=1, otherwise 0.
- SIG, output, 16: MISR contents. Present only with S298_BIST_SIG_OUT_EN defined.

## Operation
The controller is a five-state FSM: IDLE, CLEAR, RUN, FLUSH, DONE.
- IDLE: DUT_G=3'b000. On START=1 and ABORT=0, go to CLEAR, load the LFSR with the seed, set MISR=0 and load the clear counter.
- CLEAR: DUT_G=3'b001, so the core's G0 path clears its flops. After CLR_CYCLES cycles, go to RUN and load the pattern counter with PAT_CNT.
- RUN: DUT_G=lfsr[2:0]. The LFSR advances every cycle. After PAT_CNT cycles, go to FLUSH.
- FLUSH: one cycle with DUT_G=3'b000, then go to DONE.
- DONE: DONE=1, BUSY=0, PASS=(MISR==GOLDEN_SIG). PASS and DONE are held.
  - START=1 goes to CLEAR, which re-runs the test from a fresh seed and MISR.
  - ABORT=1 goes to IDLE.
- ABORT=1 in any state: next state is IDLE, and DONE and PASS drop to 0. The LFSR and MISR are not modified.

LFSR:
- 8-bit Fibonacci, shifting left: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Sequence from 8'h01: 01, 02, 04, 08, 11, 23, …

MISR:
- 16-bit, polynomial 16'h1021: next = {m[14:0],1'b0} ^ (m[15] ? 16'h1021 : 0) ^ {10'b0, OBS}.
- Updates in every RUN cycle except the first, and in FLUSH. This gives exactly PAT_CNT captures; each captured OBS is the core's response to the previous cycle's pattern.
- Holds in all other states.

Counters:
- The clear counter is 4 bits and the pattern counter is 16 bits. Both count down and stop at their terminal value.
- No wrap-around is possible within the legal parameter range.

## Timing
- Reset (RN=0), immediately and asynchronously: state=IDLE, DUT_G=0, BUSY=0, DONE=0, PASS=0, lfsr=seed, MISR=0, SIG=0.
- Reset mid-test aborts the test; no partial result is reported.
- START sampled at edge T:
  - CLEAR occupies T+1 .. T+CLR_CYCLES.
  - RUN occupies the next PAT_CNT cycles.
  - FLUSH takes 1 cycle.
  - DONE and PASS first assert CLR_CYCLES+PAT_CNT+2 cycles after T.
- START during BUSY is ignored. START and ABORT together in IDLE or DONE go to IDLE.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- S298_BIST_SIG_OUT_EN defined:
  - The SIG[15:0] port exists and mirrors the MISR every cycle.
  - This allows golden-signature characterisation.
- Not defined:
  - The SIG port and its logic are absent.
  - Only PASS reports the result; the internal behaviour is otherwise identical.

## Test plan
- Reset: RN low with CK running -> DUT_G=0, BUSY=0, DONE=0, PASS=0, SIG=16'h0000. Release RN -> state stays IDLE.
- Pattern sequence: LFSR_SEED=8'h01, CLR_CYCLES=2, START pulse -> DUT_G = 001, 001, then 001, 010, 100, 000, 001, 011 in the first six RUN cycles.
- MISR with constant response: OBS tied to 6'h00 for a whole test -> SIG=16'h0000 at DONE. PASS=1 when GOLDEN_SIG=16'h0000, PASS=0 when GOLDEN_SIG=16'h1234.
- Latency: PAT_CNT=4, CLR_CYCLES=1, OBS=6'h01 constant -> DONE rises exactly 7 cycles after the START edge, with SIG=16'h000F (four captures of 1 into shift-xor: 1, 3, 7, F).
- Abort: ABORT asserted in the third RUN cycle -> IDLE on the next edge, BUSY=0, DONE=0, DUT_G=0. A following START restarts from CLEAR with the seed reloaded.
- Restart and ignore: START held high throughout RUN -> no restart. START in DONE -> DONE drops and CLEAR begins on the next edge; the second run gives an identical SIG.

Source files
------------

// File: rtl/s298_bist_ctrl.sv
// s298_bist_ctrl: built-in self-test sequencer for the s298 core.
// Clears the core through G0, drives LFSR patterns on {G2,G1,G0}, compacts
// the six core outputs into a 16-bit MISR and compares against GOLDEN_SIG.
// Optional feature macro: S298_BIST_SIG_OUT_EN exposes the MISR on SIG.
// Handshake: START is a level request sampled only in IDLE/DONE; ABORT wins
// over START in every state; DONE/PASS are held until START, ABORT or reset.
module s298_bist_ctrl #(
  parameter int unsigned PAT_CNT    = 255,
  parameter int unsigned CLR_CYCLES = 2,
  parameter logic [7:0]  LFSR_SEED  = 8'h01,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        START,
  input  logic        ABORT,
  input  logic [5:0]  OBS,
  output logic [2:0]  DUT_G,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
`ifdef S298_BIST_SIG_OUT_EN
  output logic [15:0] SIG,
`endif
  output logic [2:0]  DBG_STATE
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [3:0]  CLR_LOAD = 4'(CLR_CYCLES);
  localparam logic [15:0] PAT_LOAD = 16'(PAT_CNT);
  // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
  localparam logic [7:0]  SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic [2:0]  state, state_nx;
  logic [3:0]  clr_cnt, clr_nx;
  logic [15:0] pat_cnt, pat_nx;
  logic [7:0]  lfsr, lfsr_nx, lfsr_step;
  logic [15:0] misr, misr_nx, misr_step;
  logic [2:0]  g_nx;

  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign misr_step = {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000)
                   ^ {10'b0, OBS};

  // Next-state, counter, LFSR and MISR update logic.
  always_comb begin
    state_nx = state;
    clr_nx   = clr_cnt;
    pat_nx   = pat_cnt;
    lfsr_nx  = lfsr;
    misr_nx  = misr;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_nx = ST_CLEAR;
          clr_nx   = CLR_LOAD;
          lfsr_nx  = SEED_EFF;
          misr_nx  = 16'h0000;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt <= 4'd1) begin
          state_nx = ST_RUN;
          pat_nx   = PAT_LOAD;
        end else begin
          clr_nx = clr_cnt - 4'd1;
        end
      end
      ST_RUN: begin
        // The first RUN cycle has no response to capture yet.
        if (pat_cnt != PAT_LOAD) misr_nx = misr_step;
        if (pat_cnt <= 16'd1) state_nx = ST_FLUSH;
        else                  pat_nx   = pat_cnt - 16'd1;
      end
      ST_FLUSH: begin
        // Captures the response to the last RUN pattern.
        misr_nx  = misr_step;
        state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // The pattern registered on this edge is the current LFSR value, so the
    // LFSR steps on every edge that lands in RUN.
    if (state_nx == ST_RUN) lfsr_nx = lfsr_step;
    if (ABORT) begin
      state_nx = ST_IDLE;
      clr_nx   = clr_cnt;
      pat_nx   = pat_cnt;
      lfsr_nx  = lfsr;
      misr_nx  = misr;
    end
  end

  // Core drive value for the upcoming cycle.
  always_comb begin
    g_nx = 3'b000;
    if (state_nx == ST_CLEAR)    g_nx = 3'b001;
    else if (state_nx == ST_RUN) g_nx = lfsr[2:0];
  end

  // State and registered outputs; outputs are derived from the next state.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state   <= ST_IDLE;
      clr_cnt <= 4'd0;
      pat_cnt <= 16'd0;
      lfsr    <= SEED_EFF;
      misr    <= 16'h0000;
      DUT_G   <= 3'b000;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_nx;
      pat_cnt <= pat_nx;
      lfsr    <= lfsr_nx;
      misr    <= misr_nx;
      DUT_G   <= g_nx;
      BUSY    <= (state_nx == ST_CLEAR) || (state_nx == ST_RUN) ||
                 (state_nx == ST_FLUSH);
      DONE    <= (state_nx == ST_DONE);
      PASS    <= (state_nx == ST_DONE) && (misr_nx == GOLDEN_SIG);
    end
  end

  assign DBG_STATE = state;

`ifdef S298_BIST_SIG_OUT_EN
  assign SIG = misr;
`endif

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Testbench for s298_bist_ctrl: two instances with different parameters,
// directed stimulus, and a DONE-triggered scoreboard of {PASS, SIG}.
module tb_s298_bist_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;

  logic ck, rn;
  logic a_start, a_abort, b_start, b_abort;
  logic [5:0] a_obs, b_obs;
  logic [2:0] a_g, b_g, a_dbg, b_dbg;
  logic a_busy, a_done, a_pass, b_busy, b_done, b_pass;
  logic [15:0] a_sig, b_sig;

  int checks = 0;
  int errors = 0;

  // expected {PASS, SIG} per completed run
  logic [16:0] exp_a_q[$];
  logic [16:0] exp_b_q[$];
  logic [16:0] ea, eb;
  logic a_done_q, b_done_q;

  // ---------------- clock / reset ----------------
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  s298_bist_ctrl #(.PAT_CNT(6), .CLR_CYCLES(2), .LFSR_SEED(8'h01),
                   .GOLDEN_SIG(16'h0555)) u_a (
    .CK(ck), .RN(rn), .START(a_start), .ABORT(a_abort), .OBS(a_obs),
    .DUT_G(a_g), .BUSY(a_busy), .DONE(a_done), .PASS(a_pass),
`ifdef S298_BIST_SIG_OUT_EN
    .SIG(a_sig),
`endif
    .DBG_STATE(a_dbg)
  );

  s298_bist_ctrl #(.PAT_CNT(4), .CLR_CYCLES(1), .LFSR_SEED(8'h00),
                   .GOLDEN_SIG(16'h000F)) u_b (
    .CK(ck), .RN(rn), .START(b_start), .ABORT(b_abort), .OBS(b_obs),
    .DUT_G(b_g), .BUSY(b_busy), .DONE(b_done), .PASS(b_pass),
`ifdef S298_BIST_SIG_OUT_EN
    .SIG(b_sig),
`endif
    .DBG_STATE(b_dbg)
  );

`ifndef S298_BIST_SIG_OUT_EN
  assign a_sig = 16'h0000;
  assign b_sig = 16'h0000;
`endif

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Issue START for one cycle; returns just after the START edge (cycle 1).
  task automatic start_run(input int sel);
    if (sel == 0) a_start = 1'b1; else b_start = 1'b1;
    tick();
    if (sel == 0) a_start = 1'b0; else b_start = 1'b0;
  endtask

  // Tick until DONE; n_in is the cycle index already reached.
  task automatic wait_done(input int sel, input int n_in, input int exp_n, input string nm);
    int n;
    n = n_in;
    while (((sel == 0) ? a_done : b_done) !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(nm, n, exp_n);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge ck) begin
    if (rn && a_done && !a_done_q) begin
      if (exp_a_q.size() == 0) begin
        chk("a_unexpected_done", 1, 0);
      end else begin
        ea = exp_a_q.pop_front();
        chk("a_pass", a_pass, ea[16]);
`ifdef S298_BIST_SIG_OUT_EN
        chk("a_sig", a_sig, ea[15:0]);
`endif
      end
    end
    if (rn && b_done && !b_done_q) begin
      if (exp_b_q.size() == 0) begin
        chk("b_unexpected_done", 1, 0);
      end else begin
        eb = exp_b_q.pop_front();
        chk("b_pass", b_pass, eb[16]);
`ifdef S298_BIST_SIG_OUT_EN
        chk("b_sig", b_sig, eb[15:0]);
`endif
      end
    end
    a_done_q <= a_done;
    b_done_q <= b_done;
  end

  // ---------------- stimulus ----------------
  logic [2:0] pat_exp [8];

  initial begin
    pat_exp = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b011};
    rn = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_obs = 6'h00;
    b_start = 1'b0; b_abort = 1'b0; b_obs = 6'h00;

    // reset values
    repeat (3) tick();
    chk("rst_a_g", a_g, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_pass", a_pass, 0);
    chk("rst_a_sig", a_sig, 0);
    chk("rst_b_g", b_g, 0);
    chk("rst_b_busy", b_busy, 0);
    rn = 1'b1;
    repeat (3) tick();
    chk("post_rst_a_state", a_dbg, ST_IDLE);
    chk("post_rst_b_state", b_dbg, ST_IDLE);
    chk("post_rst_a_busy", a_busy, 0);

    // pattern sequence, START held high through RUN, OBS=3F -> SIG 0555
    a_obs = 6'h3F;
    exp_a_q.push_back({1'b1, 16'h0555});
    a_start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a_pat_%0d", i), a_g, pat_exp[i]);
      chk($sformatf("a_busy_%0d", i), a_busy, 1);
      if (i == 7) a_start = 1'b0;
      tick();
    end
    chk("a_flush_g", a_g, 0);
    chk("a_flush_busy", a_busy, 1);
    chk("a_flush_done", a_done, 0);
    wait_done(0, 9, 10, "a_latency");
    chk("a_done_busy", a_busy, 0);
    repeat (2) tick();
    chk("a_done_held", a_done, 1);
    chk("a_pass_held", a_pass, 1);

    // START in DONE: restart, identical signature
    exp_a_q.push_back({1'b1, 16'h0555});
    start_run(0);
    chk("a_restart_done", a_done, 0);
    chk("a_restart_pass", a_pass, 0);
    chk("a_restart_g", a_g, 3'b001);
    chk("a_restart_busy", a_busy, 1);
    wait_done(0, 1, 10, "a_restart_latency");

    // constant zero response: SIG 0, golden 0555 mismatches
    a_obs = 6'h00;
    exp_a_q.push_back({1'b0, 16'h0000});
    start_run(0);
    wait_done(0, 1, 10, "a_zero_latency");
    tick();
    chk("a_zero_pass", a_pass, 0);
    chk("a_zero_done", a_done, 1);

    // latency on b: CLR=1, PAT=4, OBS=01 -> SIG 000F, zero seed becomes 01
    b_obs = 6'h01;
    exp_b_q.push_back({1'b1, 16'h000F});
    start_run(1);
    chk("b_clear_g", b_g, 3'b001);
    tick();
    chk("b_run1_g", b_g, 3'b001);
    tick();
    chk("b_run2_g", b_g, 3'b010);
    wait_done(1, 3, 7, "b_latency");

    b_obs = 6'h00;
    exp_b_q.push_back({1'b0, 16'h0000});
    start_run(1);
    wait_done(1, 1, 7, "b_zero_latency");

    b_obs = 6'h3F;
    exp_b_q.push_back({1'b0, 16'h0145});
    start_run(1);
    wait_done(1, 1, 7, "b_3f_latency");

    // abort in the third RUN cycle
    a_obs = 6'h3F;
    start_run(0);
    repeat (4) tick();
    chk("a_abort_pre_g", a_g, 3'b100);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("a_abort_state", a_dbg, ST_IDLE);
    chk("a_abort_busy", a_busy, 0);
    chk("a_abort_done", a_done, 0);
    chk("a_abort_g", a_g, 0);
    repeat (3) tick();
    chk("a_abort_stays_idle", a_dbg, ST_IDLE);

    // restart after abort reloads the seed
    exp_a_q.push_back({1'b1, 16'h0555});
    start_run(0);
    chk("a_rerun_clear_g", a_g, 3'b001);
    tick();
    tick();
    chk("a_rerun_run1_g", a_g, 3'b001);
    tick();
    chk("a_rerun_run2_g", a_g, 3'b010);
    wait_done(0, 4, 10, "a_rerun_latency");

    // START and ABORT together in DONE -> IDLE
    a_start = 1'b1; a_abort = 1'b1;
    tick();
    a_start = 1'b0; a_abort = 1'b0;
    chk("a_both_state", a_dbg, ST_IDLE);
    chk("a_both_done", a_done, 0);
    chk("a_both_pass", a_pass, 0);
    chk("a_both_busy", a_busy, 0);

    // asynchronous reset mid-test: no result reported
    start_run(1);
    tick();
    #3;
    rn = 1'b0;
    #1;
    chk("b_async_rst_busy", b_busy, 0);
    chk("b_async_rst_g", b_g, 0);
    chk("b_async_rst_state", b_dbg, ST_IDLE);
    tick();
    rn = 1'b1;
    repeat (12) tick();
    chk("b_after_rst_done", b_done, 0);
    chk("b_after_rst_busy", b_busy, 0);

    tick();
    chk("a_queue_drained", exp_a_q.size(), 0);
    chk("b_queue_drained", exp_b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
